// File: rtl/clock_overlay_draw.sv
// HH:MM[:SS] text overlay for a VGA pixel stream.
// Three-stage pipeline: cell compute, glyph lookup, colour mux.
module clock_overlay_draw #(
    parameter int                 PIX_X_W      = 12,
    parameter int                 PIX_Y_W      = 12,
    parameter int                 COLOR_W      = 3,
    parameter logic [COLOR_W-1:0] FG_COLOR     = 3'b111,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 3'b000,
    parameter bit                 OVERLAY      = 1'b0,
    parameter int                 SCALE_LOG2   = 1,
    parameter bit                 SHOW_SEC     = 1'b1,
    parameter int                 BLINK_FRAMES = 30,
    parameter logic               VS_POL       = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [PIX_X_W-1:0] pix_x_i,
    input  logic [PIX_Y_W-1:0] pix_y_i,
    input  logic               pix_de_i,
    input  logic               pix_hs_i,
    input  logic               pix_vs_i,
    input  logic [COLOR_W-1:0] rgb_i,
    input  logic [PIX_X_W-1:0] org_x_i,
    input  logic [PIX_Y_W-1:0] org_y_i,
    input  logic               time_valid_i,
    input  logic [4:0]         hour_i,
    input  logic [5:0]         min_i,
    input  logic [5:0]         sec_i,
    input  logic               mode_12h_i,
    input  logic               blink_en_i,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               hs_o,
    output logic               vs_o,
    output logic               de_o
);

    localparam int S     = SCALE_LOG2;
    localparam int NCELL = SHOW_SEC ? 8 : 5;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PIX_X_W:0] BOX_W = (PIX_X_W+1)'(NCELL << (3 + S));
    localparam logic [PIX_Y_W:0] BOX_H = (PIX_Y_W+1)'(8 << S);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [3:0] C_COLON = 4'd10;
    localparam logic [3:0] C_DASH  = 4'd11;
    localparam logic [3:0] C_BLANK = 4'd12;

    function automatic logic [3:0] tens10(input logic [5:0] v);
        if (v >= 6'd50)      return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones10(input logic [5:0] v);
        return 4'(v - 6'(tens10(v)) * 6'd10);
    endfunction

    // 5x7 font, row 0 in the top five bits, col 0 is the MSB of each row
    function automatic logic [34:0] font(input logic [3:0] c);
        case (c)
            4'd0: return {5'b01110, 5'b10001, 5'b10011, 5'b10101,
                          5'b11001, 5'b10001, 5'b01110};
            4'd1: return {5'b00100, 5'b01100, 5'b00100, 5'b00100,
                          5'b00100, 5'b00100, 5'b01110};
            4'd2: return {5'b01110, 5'b10001, 5'b00001, 5'b00010,
                          5'b00100, 5'b01000, 5'b11111};
            4'd3: return {5'b11111, 5'b00010, 5'b00100, 5'b00010,
                          5'b00001, 5'b10001, 5'b01110};
            4'd4: return {5'b00010, 5'b00110, 5'b01010, 5'b10010,
                          5'b11111, 5'b00010, 5'b00010};
            4'd5: return {5'b11111, 5'b10000, 5'b11110, 5'b00001,
                          5'b00001, 5'b10001, 5'b01110};
            4'd6: return {5'b00110, 5'b01000, 5'b10000, 5'b11110,
                          5'b10001, 5'b10001, 5'b01110};
            4'd7: return {5'b11111, 5'b00001, 5'b00010, 5'b00100,
                          5'b01000, 5'b01000, 5'b01000};
            4'd8: return {5'b01110, 5'b10001, 5'b10001, 5'b01110,
                          5'b10001, 5'b10001, 5'b01110};
            4'd9: return {5'b01110, 5'b10001, 5'b10001, 5'b01111,
                          5'b00001, 5'b00010, 5'b01100};
            C_COLON: return {5'b00000, 5'b01100, 5'b01100, 5'b00000,
                             5'b01100, 5'b01100, 5'b00000};
            C_DASH:  return {5'b00000, 5'b00000, 5'b00000, 5'b11111,
                             5'b00000, 5'b00000, 5'b00000};
            default: return '0;
        endcase
    endfunction

    logic               vs_q;
    logic [4:0]         sh_hour;
    logic [5:0]         sh_min, sh_sec;
    logic               sh_h_ok, sh_m_ok, sh_s_ok;
    logic [4:0]         d_hour;
    logic [5:0]         d_min, d_sec;
    logic               d_h_ok, d_m_ok, d_s_ok;
    logic [PIX_X_W-1:0] d_org_x;
    logic [PIX_Y_W-1:0] d_org_y;
    logic               d_12h;
    logic [CNT_W-1:0]   frame_cnt;
    logic               phase;

    logic frame_start;
    logic hour_ok, min_ok, sec_ok;

    assign frame_start = (pix_vs_i == VS_POL) && (vs_q != VS_POL);
    assign hour_ok     = hour_i <= 5'd23;
    assign min_ok      = min_i <= 6'd59;
    assign sec_ok      = sec_i <= 6'd59;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_q      <= ~VS_POL;
            sh_hour   <= '0;
            sh_min    <= '0;
            sh_sec    <= '0;
            sh_h_ok   <= 1'b1;
            sh_m_ok   <= 1'b1;
            sh_s_ok   <= 1'b1;
            d_hour    <= '0;
            d_min     <= '0;
            d_sec     <= '0;
            d_h_ok    <= 1'b1;
            d_m_ok    <= 1'b1;
            d_s_ok    <= 1'b1;
            d_org_x   <= '0;
            d_org_y   <= '0;
            d_12h     <= 1'b0;
            frame_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            vs_q <= pix_vs_i;
            if (time_valid_i) begin
                sh_hour <= hour_i;
                sh_min  <= min_i;
                sh_sec  <= sec_i;
                sh_h_ok <= hour_ok;
                sh_m_ok <= min_ok;
                sh_s_ok <= sec_ok;
            end
            if (frame_start) begin
                // a strobe landing on the frame-start cycle wins
                d_hour  <= time_valid_i ? hour_i : sh_hour;
                d_min   <= time_valid_i ? min_i : sh_min;
                d_sec   <= time_valid_i ? sec_i : sh_sec;
                d_h_ok  <= time_valid_i ? hour_ok : sh_h_ok;
                d_m_ok  <= time_valid_i ? min_ok : sh_m_ok;
                d_s_ok  <= time_valid_i ? sec_ok : sh_s_ok;
                d_org_x <= org_x_i;
                d_org_y <= org_y_i;
                d_12h   <= mode_12h_i;
                if (frame_cnt == LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // stage 1: box test and cell coordinates, one extra bit to avoid wrap
    logic [PIX_X_W:0] dx;
    logic [PIX_Y_W:0] dy;
    logic             in_box;

    assign dx     = {1'b0, pix_x_i} - {1'b0, d_org_x};
    assign dy     = {1'b0, pix_y_i} - {1'b0, d_org_y};
    assign in_box = (pix_x_i >= d_org_x) && (dx < BOX_W) &&
                    (pix_y_i >= d_org_y) && (dy < BOX_H);

    logic               s1_inbox, s1_hs, s1_vs, s1_de;
    logic [2:0]         s1_cell, s1_col, s1_row;
    logic [COLOR_W-1:0] s1_rgb;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_inbox <= 1'b0;
            s1_cell  <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_rgb   <= '0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_de    <= 1'b0;
        end else begin
            s1_inbox <= in_box;
            s1_cell  <= 3'(dx >> (3 + S));
            s1_col   <= 3'(dx >> S);
            s1_row   <= 3'(dy >> S);
            s1_rgb   <= rgb_i;
            s1_hs    <= pix_hs_i;
            s1_vs    <= pix_vs_i;
            s1_de    <= pix_de_i;
        end
    end

    // stage 2: character select and glyph bit
    logic [4:0]  h_disp;
    logic [3:0]  h_t, h_o, m_t, m_o, s_t, s_o;
    logic [3:0]  code;
    logic [34:0] g;
    logic [4:0]  rbits;
    logic [7:0]  rb;
    logic        colon_on, glyph;

    always_comb begin
        h_disp = d_hour;
        if (d_12h) begin
            if (d_hour == 5'd0)       h_disp = 5'd12;
            else if (d_hour > 5'd12)  h_disp = d_hour - 5'd12;
        end
    end

    assign h_t      = tens10({1'b0, h_disp});
    assign h_o      = ones10({1'b0, h_disp});
    assign m_t      = tens10(d_min);
    assign m_o      = ones10(d_min);
    assign s_t      = tens10(d_sec);
    assign s_o      = ones10(d_sec);
    assign colon_on = !blink_en_i || phase;

    always_comb begin
        code = C_BLANK;
        case (s1_cell)
            3'd0: code = !d_h_ok ? C_DASH :
                         (d_12h && h_t == 4'd0) ? C_BLANK : h_t;
            3'd1: code = !d_h_ok ? C_DASH : h_o;
            3'd2: code = colon_on ? C_COLON : C_BLANK;
            3'd3: code = !d_m_ok ? C_DASH : m_t;
            3'd4: code = !d_m_ok ? C_DASH : m_o;
            3'd5: code = colon_on ? C_COLON : C_BLANK;
            3'd6: code = !d_s_ok ? C_DASH : s_t;
            3'd7: code = !d_s_ok ? C_DASH : s_o;
            default: code = C_BLANK;
        endcase
    end

    always_comb begin
        g     = font(code);
        rbits = '0;
        case (s1_row)
            3'd0: rbits = g[34:30];
            3'd1: rbits = g[29:25];
            3'd2: rbits = g[24:20];
            3'd3: rbits = g[19:15];
            3'd4: rbits = g[14:10];
            3'd5: rbits = g[9:5];
            3'd6: rbits = g[4:0];
            default: rbits = '0;
        endcase
        // cols 5..7 land on the zero padding
        rb    = {rbits, 3'b000};
        glyph = rb[3'd7 - s1_col];
    end

    logic               s2_inbox, s2_glyph, s2_hs, s2_vs, s2_de;
    logic [COLOR_W-1:0] s2_rgb;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_inbox <= 1'b0;
            s2_glyph <= 1'b0;
            s2_rgb   <= '0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            s2_de    <= 1'b0;
        end else begin
            s2_inbox <= s1_inbox;
            s2_glyph <= s1_inbox && glyph;
            s2_rgb   <= s1_rgb;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_de    <= s1_de;
        end
    end

    // stage 3: colour mux and output register
    logic [COLOR_W-1:0] box_bg;

    assign box_bg = OVERLAY ? s2_rgb : BG_COLOR;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rgb_o <= '0;
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
            de_o  <= 1'b0;
        end else begin
            hs_o <= s2_hs;
            vs_o <= s2_vs;
            de_o <= s2_de;
            if (!s2_de)         rgb_o <= '0;
            else if (!s2_inbox) rgb_o <= s2_rgb;
            else if (s2_glyph)  rgb_o <= FG_COLOR;
            else                rgb_o <= box_bg;
        end
    end

endmodule

// File: tb/tb_clock_overlay_draw.sv
// Directed bench for clock_overlay_draw: reset, digits, 12h, invalid,
// clipping, blink and overlay colour.
module tb_clock_overlay_draw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pix_x, pix_y, org_x, org_y;
    logic        pix_de, pix_hs, pix_vs;
    logic [2:0]  rgb_i;
    logic        time_valid, mode_12h, blink_en;
    logic [4:0]  hour;
    logic [5:0]  min, sec;
    logic [2:0]  rgb_o, ovl_rgb;
    logic        hs_o, vs_o, de_o;
    logic        ovl_hs, ovl_vs, ovl_de;

    int checks = 0;
    int passed = 0;
    int fs_count = 0;

    always #5 clk = ~clk;

    clock_overlay_draw #(.BLINK_FRAMES(2)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_de_i(pix_de),
        .pix_hs_i(pix_hs), .pix_vs_i(pix_vs), .rgb_i(rgb_i),
        .org_x_i(org_x), .org_y_i(org_y), .time_valid_i(time_valid),
        .hour_i(hour), .min_i(min), .sec_i(sec), .mode_12h_i(mode_12h),
        .blink_en_i(blink_en), .rgb_o(rgb_o), .hs_o(hs_o), .vs_o(vs_o),
        .de_o(de_o)
    );

    clock_overlay_draw #(.BLINK_FRAMES(2), .OVERLAY(1'b1)) u_ovl (
        .clk_i(clk), .rst_n_i(rst_n),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_de_i(pix_de),
        .pix_hs_i(pix_hs), .pix_vs_i(pix_vs), .rgb_i(rgb_i),
        .org_x_i(org_x), .org_y_i(org_y), .time_valid_i(time_valid),
        .hour_i(hour), .min_i(min), .sec_i(sec), .mode_12h_i(mode_12h),
        .blink_en_i(blink_en), .rgb_o(ovl_rgb), .hs_o(ovl_hs),
        .vs_o(ovl_vs), .de_o(ovl_de)
    );

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic px(input string tag, input int x, input int y,
                      input logic [2:0] rgb, input logic de,
                      input logic [2:0] exp);
        @(negedge clk);
        pix_x  = 12'(x);
        pix_y  = 12'(y);
        rgb_i  = rgb;
        pix_de = de;
        repeat (3) @(posedge clk);
        #1;
        chk(tag, rgb_o, exp);
    endtask

    task automatic strobe(input logic [4:0] h, input logic [5:0] m,
                          input logic [5:0] s);
        @(negedge clk);
        time_valid = 1'b1;
        hour = h; min = m; sec = s;
        @(negedge clk);
        time_valid = 1'b0;
    endtask

    task automatic frame_start(input bit with_strobe, input logic [4:0] h,
                               input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        pix_vs = 1'b0;
        if (with_strobe) begin
            time_valid = 1'b1;
            hour = h; min = m; sec = s;
        end
        @(negedge clk);
        time_valid = 1'b0;
        @(negedge clk);
        pix_vs = 1'b1;
        fs_count++;
    endtask

    initial begin
        rst_n = 1'b0;
        pix_x = 12'd2; pix_y = 12'd0;
        pix_de = 1'b1; pix_hs = 1'b1; pix_vs = 1'b1;
        rgb_i = 3'b101;
        org_x = '0; org_y = '0;
        time_valid = 1'b0; hour = '0; min = '0; sec = '0;
        mode_12h = 1'b0; blink_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", rgb_o, 3'b000);
        chk("rst_hs", {2'b0, hs_o}, 3'b000);
        chk("rst_vs", {2'b0, vs_o}, 3'b000);
        chk("rst_de", {2'b0, de_o}, 3'b000);

        @(negedge clk);
        rst_n = 1'b1;
        pix_hs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("vs_idle", {2'b0, vs_o}, 3'b001);

        @(negedge clk);
        pix_hs = 1'b1;
        @(negedge clk);
        pix_hs = 1'b0;
        @(posedge clk); #1;
        chk("hs_lat2", {2'b0, hs_o}, 3'b000);
        @(posedge clk); #1;
        chk("hs_lat3", {2'b0, hs_o}, 3'b001);
        @(posedge clk); #1;
        chk("hs_lat4", {2'b0, hs_o}, 3'b000);

        // first frame: 00:00:00 at (0,0)
        px("f0_glyph", 2, 0, 3'b010, 1'b1, 3'b111);
        chk("ovl_glyph", ovl_rgb, 3'b111);
        chk("de_o_hi", {2'b0, de_o}, 3'b001);
        px("f0_bg", 0, 0, 3'b010, 1'b1, 3'b000);
        chk("ovl_bg", ovl_rgb, 3'b010);
        px("outside", 200, 0, 3'b010, 1'b1, 3'b010);
        px("de_low", 2, 0, 3'b010, 1'b0, 3'b000);
        px("colon_24", 34, 4, 3'b010, 1'b1, 3'b111);

        // mid-frame strobe must not affect the current frame
        mode_12h = 1'b1;
        strobe(5'd13, 6'd45, 6'd7);
        px("mid_frame", 2, 0, 3'b010, 1'b1, 3'b111);
        frame_start(1'b0, '0, '0, '0);
        px("h12_blank", 2, 0, 3'b010, 1'b1, 3'b000);
        px("h12_one_on", 20, 0, 3'b010, 1'b1, 3'b111);
        px("h12_one_off", 18, 0, 3'b010, 1'b1, 3'b000);
        px("min4_row4", 48, 8, 3'b010, 1'b1, 3'b111);
        px("min4_row0c3", 54, 0, 3'b010, 1'b1, 3'b111);
        px("min4_row0c0", 48, 0, 3'b010, 1'b1, 3'b000);
        px("sec7_row0", 120, 0, 3'b010, 1'b1, 3'b111);

        // invalid hour: --:05:09
        mode_12h = 1'b0;
        strobe(5'd24, 6'd5, 6'd9);
        frame_start(1'b0, '0, '0, '0);
        px("dash0_row3", 0, 6, 3'b010, 1'b1, 3'b111);
        px("dash0_row0", 2, 0, 3'b010, 1'b1, 3'b000);
        px("dash1_row3", 24, 6, 3'b010, 1'b1, 3'b111);
        px("min0_row0", 50, 0, 3'b010, 1'b1, 3'b111);
        px("min5_row0", 64, 0, 3'b010, 1'b1, 3'b111);
        px("sec9_c0", 112, 6, 3'b010, 1'b1, 3'b000);
        px("sec9_c4", 120, 6, 3'b010, 1'b1, 3'b111);

        // strobe coinciding with frame start: 02:03:04
        frame_start(1'b1, 5'd2, 6'd3, 6'd4);
        px("co_two_r6", 16, 12, 3'b010, 1'b1, 3'b111);
        px("co_lead0", 2, 0, 3'b010, 1'b1, 3'b111);
        px("co_three", 64, 0, 3'b010, 1'b1, 3'b111);

        // right-edge clipping at org (600,10)
        org_x = 12'd600;
        org_y = 12'd10;
        frame_start(1'b1, 5'd0, 6'd0, 6'd0);
        px("clip_left", 599, 10, 3'b010, 1'b1, 3'b010);
        px("clip_glyph", 602, 10, 3'b010, 1'b1, 3'b111);
        px("clip_bg", 600, 10, 3'b010, 1'b1, 3'b000);
        px("clip_right", 728, 10, 3'b010, 1'b1, 3'b010);
        px("clip_639", 639, 10, 3'b010, 1'b1, 3'b000);
        px("clip_above", 602, 9, 3'b010, 1'b1, 3'b010);
        px("clip_below", 602, 26, 3'b010, 1'b1, 3'b010);

        // colon blink with two frames per half-period
        org_x = '0;
        org_y = '0;
        frame_start(1'b0, '0, '0, '0);
        blink_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            px("blink", 34, 4, 3'b010, 1'b1,
               (((fs_count >> 1) & 1) == 0) ? 3'b111 : 3'b000);
            frame_start(1'b0, '0, '0, '0);
        end
        frame_start(1'b0, '0, '0, '0);
        px("blink_off_frame", 34, 4, 3'b010, 1'b1, 3'b000);
        blink_en = 1'b0;
        px("blink_dis", 34, 4, 3'b010, 1'b1, 3'b111);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
